// File: rtl/xge_pkt_tx_gen.sv
// xge_pkt_tx_gen: packet-level traffic source for the xge_mac transmit
// packet interface. Emits a run of frames of a fixed, clamped length with a
// deterministic byte pattern, a programmable inter-packet gap, and honours
// pkt_tx_full back-pressure.
//
// Handshake: a word is transferred in every cycle where pkt_tx_val=1; there
// is no ready. pkt_tx_full sampled 1 at an edge forces pkt_tx_val=0 after that
// edge and holds data/sop/eop, so at most one word follows the MAC raising
// full.
module xge_pkt_tx_gen #(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 9600
) (
   input  logic        clk_156m25,
   input  logic        reset_156m25_n,
   input  logic        start,
   input  logic        stop,
   input  logic [15:0] cfg_pkt_num,
   input  logic [13:0] cfg_pkt_len,
   input  logic [7:0]  cfg_gap,
   input  logic        pkt_tx_full,
   output logic [63:0] pkt_tx_data,
   output logic        pkt_tx_val,
   output logic        pkt_tx_sop,
   output logic        pkt_tx_eop,
   output logic [2:0]  pkt_tx_mod,
   output logic        busy,
   output logic        done,
   output logic [31:0] pkt_sent_cnt,
   output logic [1:0]  fsm_state
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [15:0] pidx_q, pidx_d;
   logic [11:0] word_q, word_d;
   logic [11:0] words_q, words_d;
   logic [2:0]  lmod_q, lmod_d;
   logic [15:0] num_q, num_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [7:0]  gap_q, gap_d;
   logic [7:0]  gap_cnt_q, gap_cnt_d;
   logic        stop_pend_q, stop_pend_d;
   logic        fin_q, fin_d;

   logic [63:0] data_q, data_d;
   logic        val_q, val_d;
   logic        sop_q, sop_d;
   logic        eop_q, eop_d;
   logic [2:0]  mod_q, mod_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] cnt_q, cnt_d;

   logic [13:0] len_clamped;
   logic [14:0] len_round;
   logic [11:0] words_cfg;
   logic        last_word;
   logic [7:0]  base_byte;
   logic [63:0] word_data;

   // Clamp the requested length and derive words per frame.
   always_comb begin
      len_clamped = cfg_pkt_len;
      if (cfg_pkt_len < 14'(MIN_LEN)) begin
         len_clamped = 14'(MIN_LEN);
      end else if (cfg_pkt_len > 14'(MAX_LEN)) begin
         len_clamped = 14'(MAX_LEN);
      end
      len_round = {1'b0, len_clamped} + 15'd7;
      words_cfg = len_round[14:3];
   end

   // Pattern word for the current frame/word; tail bytes of the eop word are 0.
   always_comb begin
      last_word = (word_q == (words_q - 12'd1));
      base_byte = pidx_q[7:0] + {word_q[4:0], 3'b000};
      word_data = '0;
      for (int k = 0; k < 8; k++) begin
         if (last_word && (lmod_q != 3'd0) && (3'(k) >= lmod_q)) begin
            word_data[63 - 8*k -: 8] = 8'h00;
         end else begin
            word_data[63 - 8*k -: 8] = base_byte + 8'(k);
         end
      end
   end

   // Next-state logic for the run FSM and all registered outputs.
   always_comb begin
      state_d     = state_q;
      pidx_d      = pidx_q;
      word_d      = word_q;
      words_d     = words_q;
      lmod_d      = lmod_q;
      num_d       = num_q;
      frame_cnt_d = frame_cnt_q;
      gap_d       = gap_q;
      gap_cnt_d   = gap_cnt_q;
      stop_pend_d = stop_pend_q;
      fin_d       = 1'b0;
      data_d      = data_q;
      val_d       = 1'b0;
      sop_d       = sop_q;
      eop_d       = eop_q;
      mod_d       = mod_q;
      cnt_d       = cnt_q;
      done_d      = fin_q;

      case (state_q)
         ST_IDLE: begin
            data_d      = '0;
            sop_d       = 1'b0;
            eop_d       = 1'b0;
            mod_d       = 3'd0;
            stop_pend_d = 1'b0;
            // fin_q marks the eop cycle of the previous run, where busy is still 1.
            if (start && !fin_q) begin
               state_d     = ST_SEND;
               num_d       = cfg_pkt_num;
               gap_d       = cfg_gap;
               words_d     = words_cfg;
               lmod_d      = len_clamped[2:0];
               word_d      = '0;
               frame_cnt_d = '0;
            end
         end
         ST_SEND: begin
            stop_pend_d = stop_pend_q | stop;
            if (!pkt_tx_full) begin
               val_d  = 1'b1;
               sop_d  = (word_q == 12'd0);
               eop_d  = last_word;
               mod_d  = last_word ? lmod_q : 3'd0;
               data_d = word_data;
               if (last_word) begin
                  pidx_d      = pidx_q + 16'd1;
                  cnt_d       = cnt_q + 32'd1;
                  frame_cnt_d = frame_cnt_q + 16'd1;
                  word_d      = '0;
                  if (((num_q != 16'd0) && (frame_cnt_d == num_q)) || stop_pend_d) begin
                     state_d = ST_IDLE;
                     fin_d   = 1'b1;
                  end else if (gap_q != 8'd0) begin
                     state_d   = ST_GAP;
                     gap_cnt_d = gap_q;
                  end
               end else begin
                  word_d = word_q + 12'd1;
               end
            end
         end
         ST_GAP: begin
            stop_pend_d = stop_pend_q | stop;
            data_d      = '0;
            sop_d       = 1'b0;
            eop_d       = 1'b0;
            mod_d       = 3'd0;
            gap_cnt_d   = gap_cnt_q - 8'd1;
            if (gap_cnt_q <= 8'd1) begin
               if (stop_pend_d) begin
                  state_d = ST_IDLE;
                  fin_d   = 1'b1;
               end else begin
                  state_d = ST_SEND;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE) | fin_d;
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_156m25) begin
      if (!reset_156m25_n) begin
         state_q     <= ST_IDLE;
         pidx_q      <= '0;
         word_q      <= '0;
         words_q     <= '0;
         lmod_q      <= '0;
         num_q       <= '0;
         frame_cnt_q <= '0;
         gap_q       <= '0;
         gap_cnt_q   <= '0;
         stop_pend_q <= 1'b0;
         fin_q       <= 1'b0;
         data_q      <= '0;
         val_q       <= 1'b0;
         sop_q       <= 1'b0;
         eop_q       <= 1'b0;
         mod_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         pidx_q      <= pidx_d;
         word_q      <= word_d;
         words_q     <= words_d;
         lmod_q      <= lmod_d;
         num_q       <= num_d;
         frame_cnt_q <= frame_cnt_d;
         gap_q       <= gap_d;
         gap_cnt_q   <= gap_cnt_d;
         stop_pend_q <= stop_pend_d;
         fin_q       <= fin_d;
         data_q      <= data_d;
         val_q       <= val_d;
         sop_q       <= sop_d;
         eop_q       <= eop_d;
         mod_q       <= mod_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cnt_q       <= cnt_d;
      end
   end

   assign pkt_tx_data  = data_q;
   assign pkt_tx_val   = val_q;
   assign pkt_tx_sop   = sop_q;
   assign pkt_tx_eop   = eop_q;
   assign pkt_tx_mod   = mod_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign pkt_sent_cnt = cnt_q;
   assign fsm_state    = state_q;

endmodule
